// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default baud divisor and frame geometry.
// Kept separate so the receiver can reuse the same encoding and constants.
package uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

   // 50 MHz clock, 115200 baud
   localparam int CLKS_PER_BIT_DEF = 434;
   localparam int DATA_BITS        = 8;
   localparam int FRAME_BITS       = 10;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each serial bit.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic bit_tick
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clear) count <= '0;
      else              count <= count + CNT_W'(1);
   end

   assign bit_tick = (count == CNT_W'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit; every output is registered.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_send,
   input  logic [7:0] data,
   output logic       uart_ready,
   output logic       tx,
   output logic       tx_done
);

   uart_state_t          state;
   logic [DATA_BITS-1:0] shreg;
   logic [2:0]           bit_idx;
   logic                 bit_tick;
   logic                 baud_clear;
   logic                 accept;

   assign accept = uart_ready & uart_send;

   // Holding the counter clear while idle makes acceptance start a fresh bit period.
   assign baud_clear = (state == IDLE) | bit_tick;

   uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk      (clk),
      .rst      (rst),
      .clear    (baud_clear),
      .bit_tick (bit_tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         shreg      <= '0;
         bit_idx    <= '0;
         tx         <= 1'b1;
         uart_ready <= 1'b1;
         tx_done    <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               shreg      <= data;
               state      <= START;
               tx         <= 1'b0;
               uart_ready <= 1'b0;
            end
            START: if (bit_tick) begin
               tx    <= shreg[0];
               shreg <= shreg >> 1;
               state <= DATA;
            end
            DATA: if (bit_tick) begin
               if (bit_idx == 3'(DATA_BITS - 1)) begin
                  tx      <= 1'b1;
                  bit_idx <= '0;
                  state   <= STOP;
               end else begin
                  tx      <= shreg[0];
                  shreg   <= shreg >> 1;
                  bit_idx <= bit_idx + 3'd1;
               end
            end
            STOP: if (bit_tick) begin
               state      <= IDLE;
               uart_ready <= 1'b1;
               tx_done    <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
